// File: rtl/riscv_pkg.sv
// Shared core definitions for the integer register file.
// Provides default data width and register count, the register address
// type and the hardwired-zero register index.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned REG_AW        = $clog2(NREGS_DEFAULT);

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   we_i, wr_addr_i     write-port enables / addresses
//   wr_release_i        per-port "clear busy of wr_addr" request
//   rsv_i, rsv_addr_i   reserve (mark busy) request
//   flush_i             clear all busy bits
//   busy_o              current busy vector (bit 0 always 0)
//   busy_cnt_o          popcount of busy_o
module rf_scoreboard
    import riscv_pkg::*;
#(
    parameter  int unsigned NREGS  = NREGS_DEFAULT,
    parameter  int unsigned NWRITE = 1,
    localparam int unsigned AW     = $clog2(NREGS),
    localparam int unsigned CW     = $clog2(NREGS + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NWRITE-1:0]          we_i,
    input  logic [NWRITE-1:0][AW-1:0]  wr_addr_i,
    input  logic [NWRITE-1:0]          wr_release_i,
    input  logic                       rsv_i,
    input  logic [AW-1:0]              rsv_addr_i,
    input  logic                       flush_i,
    output logic [NREGS-1:0]           busy_o,
    output logic [CW-1:0]              busy_cnt_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] release_hit;

    // Registers released by any enabled write port this cycle.
    always_comb begin
        release_hit = '0;
        for (int unsigned j = 0; j < NWRITE; j++) begin
            if (we_i[j] && wr_release_i[j]) begin
                release_hit[wr_addr_i[j]] = 1'b1;
            end
        end
    end

    // Per-register priority: reserve > flush > release > hold. x0 never busy.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (rsv_i && (rsv_addr_i == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (flush_i) begin
                busy_d[r] = 1'b0;
            end else if (release_hit[r]) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Popcount of the busy vector.
    always_comb begin
        busy_cnt_o = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            busy_cnt_o = busy_cnt_o + CW'(busy_q[r]);
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with pending-write scoreboard.
// x0 reads as zero and is never busy. Reads are combinational.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   rd_addr_i / rd_data_o / rd_busy_o  NREAD read ports (data + busy flag)
//   we_i / wr_addr_i / wr_data_i       NWRITE write ports (port 1 wins on conflict)
//   wr_release_i                       per-port busy clear of wr_addr
//   rsv_i / rsv_addr_i                 reserve a destination register
//   flush_i                            clear all busy bits
//   busy_cnt_o                         number of busy registers
// Optional build macro REGFILE_SB_BYPASS_EN: same-cycle write-to-read bypass
// on the read ports (data and busy); sequential behaviour is unchanged.
module regfile_sb
    import riscv_pkg::*;
#(
    parameter  int unsigned XLEN   = XLEN_DEFAULT,
    parameter  int unsigned NREGS  = NREGS_DEFAULT,
    parameter  int unsigned NREAD  = 2,
    parameter  int unsigned NWRITE = 1,
    localparam int unsigned AW     = $clog2(NREGS),
    localparam int unsigned CW     = $clog2(NREGS + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NREAD-1:0][AW-1:0]    rd_addr_i,
    output logic [NREAD-1:0][XLEN-1:0]  rd_data_o,
    output logic [NREAD-1:0]            rd_busy_o,
    input  logic [NWRITE-1:0]           we_i,
    input  logic [NWRITE-1:0][AW-1:0]   wr_addr_i,
    input  logic [NWRITE-1:0][XLEN-1:0] wr_data_i,
    input  logic [NWRITE-1:0]           wr_release_i,
    input  logic                        rsv_i,
    input  logic [AW-1:0]               rsv_addr_i,
    input  logic                        flush_i,
    output logic [CW-1:0]               busy_cnt_o
);

    localparam logic [AW-1:0] ADDR_ZERO = AW'(REG_ZERO);

    logic [XLEN-1:0]  rf_q [NREGS];
    logic [XLEN-1:0]  rf_d [NREGS];
    logic [NREGS-1:0] busy;

    rf_scoreboard #(
        .NREGS  (NREGS),
        .NWRITE (NWRITE)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .we_i         (we_i),
        .wr_addr_i    (wr_addr_i),
        .wr_release_i (wr_release_i),
        .rsv_i        (rsv_i),
        .rsv_addr_i   (rsv_addr_i),
        .flush_i      (flush_i),
        .busy_o       (busy),
        .busy_cnt_o   (busy_cnt_o)
    );

    // Data write; ports applied in ascending order so the highest port wins.
    always_comb begin
        rf_d = rf_q;
        for (int unsigned j = 0; j < NWRITE; j++) begin
            if (we_i[j] && (wr_addr_i[j] != ADDR_ZERO)) begin
                rf_d[wr_addr_i[j]] = wr_data_i[j];
            end
        end
        rf_d[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                rf_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                rf_q[r] <= rf_d[r];
            end
        end
    end

`ifdef REGFILE_SB_BYPASS_EN
    logic [NREAD-1:0] byp_hit;
    logic [NREAD-1:0] byp_rel;
    logic [NREAD-1:0] byp_rsv;
`endif

    // Read ports; x0 forced to zero / not busy.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
`ifdef REGFILE_SB_BYPASS_EN
        byp_hit = '0;
        byp_rel = '0;
        byp_rsv = '0;
`endif
        for (int unsigned k = 0; k < NREAD; k++) begin
            if (rd_addr_i[k] != ADDR_ZERO) begin
                rd_data_o[k] = rf_q[rd_addr_i[k]];
                rd_busy_o[k] = busy[rd_addr_i[k]];
`ifdef REGFILE_SB_BYPASS_EN
                // Bypass is held off during reset so reads stay zero.
                for (int unsigned j = 0; j < NWRITE; j++) begin
                    if (rst_ni && we_i[j] && (wr_addr_i[j] == rd_addr_i[k])) begin
                        rd_data_o[k] = wr_data_i[j];
                        byp_hit[k]   = 1'b1;
                        byp_rel[k]   = byp_rel[k] | wr_release_i[j];
                    end
                end
                byp_rsv[k] = rsv_i && (rsv_addr_i == rd_addr_i[k]);
                if (byp_hit[k]) begin
                    if (byp_rsv[k]) begin
                        rd_busy_o[k] = 1'b1;
                    end else if (byp_rel[k]) begin
                        rd_busy_o[k] = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (NREAD=3, NWRITE=2): directed scenarios
// with literal expectations plus randomized traffic against a behavioural model.
module tb_regfile_sb;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned NREAD  = 3;
    localparam int unsigned NWRITE = 2;
    localparam int unsigned AW     = 5;
    localparam int unsigned CW     = 6;

    logic                        clk;
    logic                        rst_n;
    logic [NREAD-1:0][AW-1:0]    rd_addr;
    logic [NREAD-1:0][XLEN-1:0]  rd_data;
    logic [NREAD-1:0]            rd_busy;
    logic [NWRITE-1:0]           we;
    logic [NWRITE-1:0][AW-1:0]   wr_addr;
    logic [NWRITE-1:0][XLEN-1:0] wr_data;
    logic [NWRITE-1:0]           wr_rel;
    logic                        rsv;
    logic [AW-1:0]               rsv_addr;
    logic                        flush;
    logic [CW-1:0]               busy_cnt;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [XLEN-1:0] m_rf   [NREGS];
    logic            m_busy [NREGS];

    regfile_sb #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .NWRITE (NWRITE)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .we_i         (we),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .wr_release_i (wr_rel),
        .rsv_i        (rsv),
        .rsv_addr_i   (rsv_addr),
        .flush_i      (flush),
        .busy_cnt_o   (busy_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(3) == 0) return AW'($urandom_range(3));
        return AW'($urandom_range(NREGS - 1));
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_rf[r]   = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Apply one clock edge's worth of architectural effects.
    task automatic model_clk();
        bit released [NREGS];
        for (int r = 0; r < NREGS; r++) released[r] = 1'b0;
        for (int j = 0; j < NWRITE; j++) begin
            if (we[j] && wr_addr[j] != 0) begin
                m_rf[wr_addr[j]] = wr_data[j];
                if (wr_rel[j]) released[wr_addr[j]] = 1'b1;
            end
        end
        for (int r = 1; r < NREGS; r++) begin
            if (rsv && rsv_addr == AW'(r))  m_busy[r] = 1'b1;
            else if (flush)                 m_busy[r] = 1'b0;
            else if (released[r])           m_busy[r] = 1'b0;
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int r = 0; r < NREGS; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    task automatic model_read(input int k, output logic [XLEN-1:0] d, output logic b);
        logic [AW-1:0] a;
        a = rd_addr[k];
        d = '0;
        b = 1'b0;
        if (a != 0) begin
            d = m_rf[a];
            b = m_busy[a];
`ifdef REGFILE_SB_BYPASS_EN
            begin
                bit hit = 0;
                bit rel = 0;
                for (int j = 0; j < NWRITE; j++) begin
                    if (we[j] && wr_addr[j] == a) begin
                        d = wr_data[j];
                        hit = 1;
                        rel = rel | wr_rel[j];
                    end
                end
                if (hit) begin
                    if (rsv && rsv_addr == a) b = 1'b1;
                    else if (rel)             b = 1'b0;
                end
            end
`endif
        end
    endtask

    // Compare all outputs against the model mid-cycle, then advance one edge.
    task automatic cyc();
        logic [XLEN-1:0] d;
        logic            b;
        @(negedge clk);
        for (int k = 0; k < NREAD; k++) begin
            model_read(k, d, b);
            chk($sformatf("rd_data[%0d]", k), rd_data[k], d);
            chk($sformatf("rd_busy[%0d]", k), 32'(rd_busy[k]), 32'(b));
        end
        chk("busy_cnt", 32'(busy_cnt), 32'(model_cnt()));
        @(posedge clk);
        model_clk();
        #1;
    endtask

    task automatic idle();
        we       = '0;
        wr_rel   = '0;
        rsv      = 1'b0;
        flush    = 1'b0;
        for (int j = 0; j < NWRITE; j++) begin
            wr_addr[j] = pick_addr();
            wr_data[j] = $urandom;
        end
        rsv_addr = pick_addr();
    endtask

    initial begin
        rst_n   = 1'b0;
        rd_addr = '0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: write/reserve x5, then asynchronous reset mid-cycle
        idle();
        we[0] = 1'b1; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
        rsv = 1'b1; rsv_addr = 5'd5;
        cyc();
        idle(); rd_addr[0] = 5'd5; #1;
        chk("x5_data", rd_data[0], 32'hDEADBEEF);
        chk("x5_busy", 32'(rd_busy[0]), 32'd1);
        chk("x5_cnt", 32'(busy_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_data", rd_data[0], 32'h0);
        chk("rst_busy", 32'(rd_busy[0]), 32'd0);
        chk("rst_cnt", 32'(busy_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 2: write x3 with release; same-cycle and next-cycle reads
        idle();
        we[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 32'h12345678; wr_rel[0] = 1'b1;
        rd_addr[0] = 5'd3; #1;
`ifdef REGFILE_SB_BYPASS_EN
        chk("x3_same", rd_data[0], 32'h12345678);
`else
        chk("x3_same", rd_data[0], 32'h0);
`endif
        cyc();
        idle(); #1;
        chk("x3_next", rd_data[0], 32'h12345678);

        // 3: reserve x7, write without release, then release
        idle(); rsv = 1'b1; rsv_addr = 5'd7;
        cyc();
        idle(); rd_addr[0] = 5'd7; #1;
        chk("x7_busy_rsv", 32'(rd_busy[0]), 32'd1);
        chk("x7_cnt_rsv", 32'(busy_cnt), 32'd1);
        we[0] = 1'b1; wr_addr[0] = 5'd7; wr_data[0] = 32'h00000077;
        cyc();
        idle(); #1;
        chk("x7_busy_norel", 32'(rd_busy[0]), 32'd1);
        we[1] = 1'b1; wr_addr[1] = 5'd7; wr_data[1] = 32'h00000777; wr_rel[1] = 1'b1;
        cyc();
        idle(); #1;
        chk("x7_busy_rel", 32'(rd_busy[0]), 32'd0);
        chk("x7_cnt_rel", 32'(busy_cnt), 32'd0);

        // 4: reserve + release-write x9 with flush while x4 busy
        idle(); rsv = 1'b1; rsv_addr = 5'd4;
        cyc();
        idle();
        rsv = 1'b1; rsv_addr = 5'd9; flush = 1'b1;
        we[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 32'hCAFEF00D; wr_rel[0] = 1'b1;
        cyc();
        idle(); rd_addr[0] = 5'd9; rd_addr[1] = 5'd4; #1;
        chk("x9_busy", 32'(rd_busy[0]), 32'd1);
        chk("x4_busy", 32'(rd_busy[1]), 32'd0);
        chk("flush_cnt", 32'(busy_cnt), 32'd1);
        chk("x9_data", rd_data[0], 32'hCAFEF00D);

        // 5: write and reserve on x0 are ignored
        idle();
        we[1] = 1'b1; wr_addr[1] = 5'd0; wr_data[1] = 32'hFFFFFFFF; wr_rel[1] = 1'b1;
        rsv = 1'b1; rsv_addr = 5'd0;
        cyc();
        idle(); rd_addr[0] = 5'd0; #1;
        chk("x0_data", rd_data[0], 32'h0);
        chk("x0_busy", 32'(rd_busy[0]), 32'd0);
        chk("x0_cnt", 32'(busy_cnt), 32'd1);

        // 6: dual write to x10, port 1 wins data, release from port 0 only
        idle(); rsv = 1'b1; rsv_addr = 5'd10;
        cyc();
        idle();
        we = 2'b11;
        wr_addr[0] = 5'd10; wr_data[0] = 32'hAAAA0000; wr_rel[0] = 1'b1;
        wr_addr[1] = 5'd10; wr_data[1] = 32'h5555FFFF; wr_rel[1] = 1'b0;
        cyc();
        idle(); rd_addr[0] = 5'd10; #1;
        chk("x10_data", rd_data[0], 32'h5555FFFF);
        chk("x10_busy", 32'(rd_busy[0]), 32'd0);
        chk("x10_cnt", 32'(busy_cnt), 32'd1);

        // Randomized traffic with one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NREAD; k++) rd_addr[k] = pick_addr();
            for (int j = 0; j < NWRITE; j++) begin
                we[j]      = ($urandom_range(1) == 1);
                wr_addr[j] = pick_addr();
                wr_data[j] = $urandom;
                wr_rel[j]  = ($urandom_range(1) == 1);
            end
            rsv      = ($urandom_range(2) == 0);
            rsv_addr = pick_addr();
            flush    = ($urandom_range(39) == 0);
            if (i == 1500) begin
                rst_n = 1'b0;
                #1;
                chk("rand_rst_cnt", 32'(busy_cnt), 32'd0);
                model_reset();
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-port integer register file with a per-register pending-write scoreboard, for the 5-stage core and wider follow-on cores.
- Decode stage reserves a destination register on issue; the writeback stage writes data and releases the reservation.
- Read ports return data plus a busy flag, which drives hazard/stall logic.
- x0 is hardwired to zero and is never busy.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers; power of 2, minimum 2
NREAD, 2, number of combinational read ports, 1..4
NWRITE, 1, number of write ports, 1..2
AW, $clog2(NREGS), address width (derived; not overridable)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
rd_addr_i  in  NREAD x AW  read addresses
rd_data_o  out  NREAD x XLEN  read data
rd_busy_o  out  NREAD  1 = register has an outstanding reservation
we_i  in  NWRITE  write enables
wr_addr_i  in  NWRITE x AW  write addresses
wr_data_i  in  NWRITE x XLEN  write data
wr_release_i  in  NWRITE  1 = this write also clears the busy bit of wr_addr
rsv_i  in  1  reserve request
rsv_addr_i  in  AW  register to mark busy
flush_i  in  1  clear all busy bits (pipeline flush)
busy_cnt_o  out  $clog2(NREGS+1)  number of busy registers

Behaviour:
- Reset (rst_ni low, asynchronous): all registers go to 0 and all busy bits go to 0.
  - While in reset: rd_data_o = 0, rd_busy_o = 0, busy_cnt_o = 0.
  - Deassertion takes effect at the next rising edge, with no pipeline state to recover.
- Storage: rf[NREGS] x XLEN and busy[NREGS], both updated on the rising edge only.
- Read: purely combinational.
  - rd_data_o[k] = rf[rd_addr_i[k]]; rd_busy_o[k] = busy[rd_addr_i[k]].
  - Address 0 always returns data 0 and busy 0.
- Write: when we_i[j]=1 and wr_addr_i[j]!=0, rf is updated at the edge. Latency is 1: a read sees the new value in the following cycle.
- Write-write conflict (NWRITE=2, same address, both enabled): port 1 wins for data. The busy clear applies if either port requests release.
- Busy next-state priority per register r, highest first:
  1. rsv_i && rsv_addr_i==r && r!=0 -> busy=1. Reserve beats both flush and release in the same cycle, because a new producer takes over.
  2. flush_i -> busy=0.
  3. Any j with we_i[j] && wr_release_i[j] && wr_addr_i[j]==r -> busy=0.
  4. Otherwise hold.
- Write without release: data is updated and busy is unchanged (used for multi-cycle producers writing partial results).
- Release on a register that is not busy: harmless, busy stays 0.
- Reserve on an already-busy register: stays 1. There is no counting; one release clears it.
- Writes, reserves and releases to address 0: ignored in all cases.
- busy_cnt_o: combinational popcount of the busy vector. Range 0..NREGS-1, since x0 is never busy.
- X-safety: with all enables low, no state changes regardless of address/data inputs.

Optional Feature:
Macro: REGFILE_SB_BYPASS_EN
- Defined:
  - A read whose address matches an enabled write port this cycle (address != 0) returns wr_data_i of that port combinationally, port 1 winning over port 0.
  - rd_busy_o for that read is 0 if that write has release=1 and there is no same-cycle reserve of the same address; otherwise it follows the stored busy bit, forced to 1 by a same-cycle reserve of the same address.
  - Write-to-read latency becomes 0.
- Undefined: reads return only stored state; write-to-read latency is 1.
- Sequential behaviour is identical in both builds.

Decomposition:
- Shared package riscv_pkg: XLEN default, NREGS default, reg_addr_t typedef, REG_ZERO constant.
- Sub-module rf_scoreboard holds the busy vector, the priority next-state logic and the popcount. The regfile_sb top holds data storage, read muxes and the bypass.

Test Plan:
1. Reset with rst_ni low mid-operation after writing x5=0xDEADBEEF and reserving x5 -> rd_data_o=0, rd_busy_o=0 and busy_cnt_o=0 immediately, without waiting for a clock edge.
2. Write x3=0x12345678 with release, read x3 in the same cycle and the next cycle -> without bypass: old 0, then 0x12345678; with bypass: 0x12345678 in both.
3. Reserve x7; next cycle rd_busy=1 and busy_cnt=1; write x7 without release -> busy stays 1; write with release -> busy 0, busy_cnt 0.
4. Same cycle: reserve x9, release-write x9, flush_i=1 with x4 busy -> after the edge x9 busy=1, x4 busy=0, busy_cnt=1, rf[9] holds the new data.
5. Write 0xFFFFFFFF and reserve on x0 -> read x0 returns 0 with busy 0; busy_cnt unchanged.
6. NWRITE=2, both ports write x10 (0xAAAA0000 from port 0, 0x5555FFFF from port 1), release only on port 0 -> rf[10]=0x5555FFFF and busy[10]=0.
